// File: rtl/mac_pkg.sv
// -----------------------------------------------------------------------------
// mac_pkg
// Shared definitions for the multiply-accumulate datapath.
//   - state_t      : accumulator FSM state encoding (ST_ACCUM / ST_DONE)
//   - DEF_PROD_W   : default width of an incoming product
//   - DEF_ACC_W    : default accumulator / sum width
//   - DEF_CNT_W    : default beat-counter width
// -----------------------------------------------------------------------------
package mac_pkg;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_DONE  = 1'b1
    } state_t;

    localparam int DEF_PROD_W = 8;
    localparam int DEF_ACC_W  = 16;
    localparam int DEF_CNT_W  = 8;

endpackage : mac_pkg

// File: rtl/sat_adder.sv
// -----------------------------------------------------------------------------
// sat_adder
// Unsigned ACC_W-wide saturating adder. The sum is formed one bit wider so the
// carry out can be observed; on carry the result clamps to all-ones.
// Ports:
//   i_a, i_b : ACC_W-bit unsigned operands
//   o_sum    : saturated ACC_W-bit sum
//   o_sat    : 1 when the true sum did not fit (carry out)
// -----------------------------------------------------------------------------
module sat_adder #(
    parameter int ACC_W = 16
) (
    input  logic [ACC_W-1:0] i_a,
    input  logic [ACC_W-1:0] i_b,
    output logic [ACC_W-1:0] o_sum,
    output logic             o_sat
);

    logic [ACC_W:0] w_full;

    assign w_full = {1'b0, i_a} + {1'b0, i_b};
    assign o_sat  = w_full[ACC_W];
    assign o_sum  = w_full[ACC_W] ? {ACC_W{1'b1}} : w_full[ACC_W-1:0];

endmodule : sat_adder

// File: rtl/product_accumulator.sv
// -----------------------------------------------------------------------------
// product_accumulator
// Sums a burst of unsigned products from the array multiplier and hands the
// total, the beat count and a sticky saturation flag to the consumer.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   clr                 : synchronous abort; drops the burst / pending result
//   in_valid/in_ready   : product beat handshake
//   in_product, in_last : product value and end-of-burst marker
//   out_valid/out_ready : result handshake
//   out_sum, out_count  : accumulated sum and number of beats
//   out_sat             : sum saturated at some point in the burst
// -----------------------------------------------------------------------------
module product_accumulator
    import mac_pkg::*;
#(
    parameter int PROD_W = DEF_PROD_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_sat
);

    // Count value at which the accepted beat fills the counter (2^CNT_W - 2).
    localparam logic [CNT_W-1:0] CNT_LAST = {{(CNT_W-1){1'b1}}, 1'b0};

    state_t             r_state;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_sat;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [ACC_W-1:0]   r_out_sum;
    logic [CNT_W-1:0]   r_out_count;
    logic               r_out_sat;

    logic [ACC_W-1:0]   w_prod_ext;
    logic [ACC_W-1:0]   w_sum;
    logic               w_carry;
    logic               w_sat_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_beat;
    logic               w_last;

    assign w_prod_ext = {{(ACC_W-PROD_W){1'b0}}, in_product};

    sat_adder #(
        .ACC_W (ACC_W)
    ) u_sat_adder (
        .i_a   (r_acc),
        .i_b   (w_prod_ext),
        .o_sum (w_sum),
        .o_sat (w_carry)
    );

    assign w_sat_nxt = r_sat | w_carry;
    assign w_cnt_nxt = r_cnt + 1'b1;
    // in_ready is low in DONE, so a beat can only be taken while accumulating.
    assign w_beat    = in_valid & r_in_ready;
    // A burst also ends when the counter would otherwise wrap.
    assign w_last    = in_last | (r_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_ACCUM;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_sat       <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_count <= '0;
            r_out_sat   <= 1'b0;
        end else if (clr) begin
            // Abort: any beat this cycle and any pending result are dropped.
            r_state     <= ST_ACCUM;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_sat       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    // in_ready first rises one edge after reset release.
                    r_in_ready <= 1'b1;
                    if (w_beat) begin
                        r_acc <= w_sum;
                        r_cnt <= w_cnt_nxt;
                        r_sat <= w_sat_nxt;
                        if (w_last) begin
                            r_state     <= ST_DONE;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_out_sum   <= w_sum;
                            r_out_count <= w_cnt_nxt;
                            r_out_sat   <= w_sat_nxt;
                        end
                    end
                end
                ST_DONE: begin
                    // Result registers keep their values after the handshake.
                    if (out_ready) begin
                        r_state     <= ST_ACCUM;
                        r_acc       <= '0;
                        r_cnt       <= '0;
                        r_sat       <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_ACCUM;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_count = r_out_count;
    assign out_sat   = r_out_sat;

endmodule : product_accumulator

// File: tb/tb_product_accumulator.sv
module tb_product_accumulator;

    localparam int PROD_W = 8;
    localparam int ACC_W  = 10;
    localparam int CNT_W  = 3;

    typedef struct packed {
        logic [ACC_W-1:0] sum;
        logic [CNT_W-1:0] cnt;
        logic             sat;
    } exp_t;

    logic              clk;
    logic              rst;
    logic              clr;
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_product;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic [CNT_W-1:0]  out_count;
    logic              out_sat;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    product_accumulator #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W),
        .CNT_W  (CNT_W)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_product (in_product),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_count  (out_count),
        .out_sat    (out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Present one beat and hold it until the DUT takes it (bounded wait).
    task automatic send(input int p, input bit last);
        int n = 0;
        in_valid   = 1'b1;
        in_product = PROD_W'(p);
        in_last    = last;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 50) begin
                chk("send_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        in_product = PROD_W'($urandom);
        in_last    = 1'($urandom);
    endtask

    // Wait until no result is pending (bounded wait).
    task automatic wait_idle();
        int n = 0;
        forever begin
            @(negedge clk);
            if (!out_valid) break;
            n++;
            if (n > 50) begin
                chk("idle_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every result handshake is compared with the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid && out_ready && !rst) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_result", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("out_sum",   int'(out_sum),   int'(e.sum));
                    chk("out_count", int'(out_count), int'(e.cnt));
                    chk("out_sat",   int'(out_sat),   int'(e.sat));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        clr        = 1'b0;
        in_valid   = 1'b0;
        in_product = '0;
        in_last    = 1'b0;
        out_ready  = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready",  int'(in_ready),  0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_sum",   int'(out_sum),   0);
        chk("rst_out_count", int'(out_count), 0);
        chk("rst_out_sat",   int'(out_sat),   0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rel_in_ready_low", int'(in_ready), 0);
        @(posedge clk);
        #1;
        chk("rel_in_ready_high", int'(in_ready), 1);

        // 1. Basic burst: 15 + 30 + 225 = 270
        sb.push_back('{sum: 10'd270, cnt: 3'd3, sat: 1'b0});
        send(15, 0);
        send(30, 0);
        send(225, 1);
        chk("t1_latency_out_valid", int'(out_valid), 1);
        chk("t1_in_ready_low", int'(in_ready), 0);
        wait_idle();

        // 2. Backpressure: 10 + 20 held for five cycles
        out_ready = 1'b0;
        sb.push_back('{sum: 10'd30, cnt: 3'd2, sat: 1'b0});
        send(10, 0);
        send(20, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t2_hold_valid",    int'(out_valid), 1);
            chk("t2_hold_sum",      int'(out_sum),   30);
            chk("t2_hold_in_ready", int'(in_ready),  0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("t2_in_ready_after", int'(in_ready),  1);
        chk("t2_valid_dropped",  int'(out_valid), 0);
        chk("t2_sum_kept",       int'(out_sum),   30);
        sb.push_back('{sum: 10'd7, cnt: 3'd1, sat: 1'b0});
        send(7, 1);
        wait_idle();

        // 3. Saturation: 5 x 255 = 1275 clamps to 1023; next burst clean
        sb.push_back('{sum: 10'd1023, cnt: 3'd5, sat: 1'b1});
        for (int i = 0; i < 4; i++) send(255, 0);
        send(255, 1);
        wait_idle();
        sb.push_back('{sum: 10'd1, cnt: 3'd1, sat: 1'b0});
        send(1, 1);
        wait_idle();

        // 4. Forced termination after seven beats; eighth waits for handshake
        out_ready = 1'b0;
        sb.push_back('{sum: 10'd7, cnt: 3'd7, sat: 1'b0});
        for (int i = 0; i < 7; i++) send(1, 0);
        chk("t4_forced_valid", int'(out_valid), 1);
        in_valid   = 1'b1;
        in_product = 8'd1;
        in_last    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_beat8_blocked", int'(in_ready),  0);
            chk("t4_count_held",    int'(out_count), 7);
        end
        @(posedge clk);
        #1;
        sb.push_back('{sum: 10'd1, cnt: 3'd1, sat: 1'b0});
        out_ready = 1'b1;
        send(1, 1);
        wait_idle();

        // 5. Bubbles with garbage on in_product during gaps
        sb.push_back('{sum: 10'd11, cnt: 3'd2, sat: 1'b0});
        send(5, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            in_product = PROD_W'($urandom);
            in_last    = 1'($urandom);
        end
        send(6, 1);
        wait_idle();

        // 6a. clr mid-burst drops partial sum and the concurrent beat
        send(100, 0);
        send(100, 0);
        clr        = 1'b1;
        in_valid   = 1'b1;
        in_product = 8'd50;
        in_last    = 1'b1;
        @(posedge clk);
        #1;
        clr      = 1'b0;
        in_valid = 1'b0;
        chk("t6_clr_in_ready",  int'(in_ready),  1);
        chk("t6_clr_out_valid", int'(out_valid), 0);
        sb.push_back('{sum: 10'd3, cnt: 3'd1, sat: 1'b0});
        send(3, 1);
        wait_idle();

        // 6b. asynchronous reset while a result is pending
        out_ready = 1'b0;
        send(9, 1);
        @(negedge clk);
        chk("t6_done_valid", int'(out_valid), 1);
        chk("t6_done_sum",   int'(out_sum),   9);
        #1;
        rst = 1'b1;
        #1;
        chk("t6_async_valid",    int'(out_valid), 0);
        chk("t6_async_sum",      int'(out_sum),   0);
        chk("t6_async_in_ready", int'(in_ready),  0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_post_rst_in_ready", int'(in_ready), 1);

        chk("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_product_accumulator
